axi_burst_mem_slave: RTL

Parametrised AXI4 (full) burst slave with an internal word-addressed buffer, used as the image/kernel load-and-readback port of the convolution accelerator. It generalises the fixed 32-bit/12-bit AXI-full slave port to configurable data, address, ID width and depth. It adds independent write and read channel FSMs and FIXED/INCR/WRAP burst address generation. Protocol violations are reported through SLVERR responses.

---
 rtl/axi_burst_pkg.sv | 19 +
 rtl/axi_burst_addr_gen.sv | 62 ++++++
 rtl/axi_burst_mem_slave.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_pkg.sv
// Shared types and helpers for the AXI4 burst memory slave.
// Burst encodings, response codes and WRAP length check.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic wrap_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Word-granular burst address generator.
// Tracks beat count, current/next word index and range flags.
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int IDXW  = 10,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [IDXW-1:0] start,
  input  logic [7:0]      len,
  input  logic [1:0]      burst,
  output logic [IDXW-1:0] idx,
  output logic [IDXW-1:0] nxt,
  output logic            last,
  output logic            nxt_last,
  output logic            oor
);

  logic [7:0]      cnt;
  logic [7:0]      blen;
  logic [1:0]      bt;
  logic [IDXW-1:0] mask;
  logic [IDXW-1:0] inc;

  // next word index; bad WRAP lengths and reserved type fall back to INCR
  always_comb begin
    mask = IDXW'(blen);
    inc  = idx + 1'b1;
    nxt  = inc;
    if (bt == FIXED)
      nxt = idx;
    else if (bt == WRAP && wrap_ok(blen))
      nxt = (idx & ~mask) | (inc & mask);
  end

  assign last     = (cnt == blen);
  assign nxt_last = ((cnt + 8'd1) == blen);
  assign oor      = 32'(idx) >= 32'(DEPTH);

  // burst state: load on address handshake, advance per beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      cnt  <= '0;
      blen <= '0;
      bt   <= '0;
    end else if (load) begin
      idx  <= start;
      cnt  <= '0;
      blen <= len;
      bt   <= burst;
    end else if (step) begin
      idx  <= nxt;
      cnt  <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst slave over an internal word buffer.
// Independent write and read FSMs, SLVERR on protocol errors.
module axi_burst_mem_slave
  import axi_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 1,
  parameter int DEPTH      = 1024
) (
  input  logic                    s01_axi_aclk,
  input  logic                    s01_axi_areset,
  input  logic [ID_WIDTH-1:0]     s01_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s01_axi_awaddr,
  input  logic [7:0]              s01_axi_awlen,
  input  logic [2:0]              s01_axi_awsize,
  input  logic [1:0]              s01_axi_awburst,
  input  logic                    s01_axi_awvalid,
  output logic                    s01_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s01_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axi_wstrb,
  input  logic                    s01_axi_wlast,
  input  logic                    s01_axi_wvalid,
  output logic                    s01_axi_wready,
  output logic [ID_WIDTH-1:0]     s01_axi_bid,
  output logic [1:0]              s01_axi_bresp,
  output logic                    s01_axi_bvalid,
  input  logic                    s01_axi_bready,
  input  logic [ID_WIDTH-1:0]     s01_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s01_axi_araddr,
  input  logic [7:0]              s01_axi_arlen,
  input  logic [2:0]              s01_axi_arsize,
  input  logic [1:0]              s01_axi_arburst,
  input  logic                    s01_axi_arvalid,
  output logic                    s01_axi_arready,
  output logic [ID_WIDTH-1:0]     s01_axi_rid,
  output logic [DATA_WIDTH-1:0]   s01_axi_rdata,
  output logic [1:0]              s01_axi_rresp,
  output logic                    s01_axi_rlast,
  output logic                    s01_axi_rvalid,
  input  logic                    s01_axi_rready
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = ADDR_WIDTH - OFFW;
  localparam int MW   = $clog2(DEPTH);
  localparam logic [2:0] SIZE_OK = 3'(OFFW);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic hdr_err(
    input logic [2:0] size,
    input logic [1:0] burst,
    input logic [7:0] len
  );
    return (size != SIZE_OK) || (burst == 2'b11) ||
           (burst == WRAP && !wrap_ok(len));
  endfunction

  wstate_t         wstate;
  rstate_t         rstate;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic            werr;
  logic            rerr;
  logic [IDXW-1:0] aw_start;
  logic [IDXW-1:0] ar_start;
  logic            aw_hs;
  logic            w_hs;
  logic            ar_hs;
  logic            r_hs;
  logic            w_beat_err;
  logic            we;
  logic            ar_herr;
  logic            ar_oor;
  logic            r_nxt_oor;

  logic [IDXW-1:0] w_idx;
  logic [IDXW-1:0] w_nxt;
  logic            w_last;
  logic            w_nxt_last;
  logic            w_oor;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] r_nxt;
  logic            r_last;
  logic            r_nxt_last;
  logic            r_oor;
  logic            unused_ok;

  assign aw_start = IDXW'(s01_axi_awaddr >> OFFW);
  assign ar_start = IDXW'(s01_axi_araddr >> OFFW);
  assign aw_hs    = s01_axi_awvalid & s01_axi_awready;
  assign w_hs     = (wstate == W_DATA) & s01_axi_wvalid & s01_axi_wready;
  assign ar_hs    = s01_axi_arvalid & s01_axi_arready;
  assign r_hs     = s01_axi_rvalid & s01_axi_rready;

  assign w_beat_err = w_oor | (s01_axi_wlast != w_last);
  assign we         = w_hs & ~werr & ~w_beat_err;
  assign ar_herr    = hdr_err(s01_axi_arsize, s01_axi_arburst,
                              s01_axi_arlen);
  assign ar_oor     = 32'(ar_start) >= 32'(DEPTH);
  assign r_nxt_oor  = 32'(r_nxt) >= 32'(DEPTH);
  assign unused_ok  = ^{w_nxt, w_nxt_last, r_idx, r_last, r_oor};

  axi_burst_addr_gen #(.IDXW(IDXW), .DEPTH(DEPTH)) u_wgen (
    .clk      (s01_axi_aclk),
    .rst      (s01_axi_areset),
    .load     (aw_hs),
    .step     (w_hs),
    .start    (aw_start),
    .len      (s01_axi_awlen),
    .burst    (s01_axi_awburst),
    .idx      (w_idx),
    .nxt      (w_nxt),
    .last     (w_last),
    .nxt_last (w_nxt_last),
    .oor      (w_oor)
  );

  axi_burst_addr_gen #(.IDXW(IDXW), .DEPTH(DEPTH)) u_rgen (
    .clk      (s01_axi_aclk),
    .rst      (s01_axi_areset),
    .load     (ar_hs),
    .step     (r_hs & ~s01_axi_rlast),
    .start    (ar_start),
    .len      (s01_axi_arlen),
    .burst    (s01_axi_arburst),
    .idx      (r_idx),
    .nxt      (r_nxt),
    .last     (r_last),
    .nxt_last (r_nxt_last),
    .oor      (r_oor)
  );

  // byte-enable write port; contents survive reset
  always_ff @(posedge s01_axi_aclk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (s01_axi_wstrb[b])
          mem[w_idx[MW-1:0]][b*8 +: 8] <= s01_axi_wdata[b*8 +: 8];
      end
    end
  end

  // write channel FSM: AW -> W beats -> B
  always_ff @(posedge s01_axi_aclk or posedge s01_axi_areset) begin
    if (s01_axi_areset) begin
      wstate          <= W_IDLE;
      werr            <= 1'b0;
      s01_axi_awready <= 1'b0;
      s01_axi_wready  <= 1'b0;
      s01_axi_bvalid  <= 1'b0;
      s01_axi_bresp   <= RESP_OKAY;
      s01_axi_bid     <= '0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            s01_axi_awready <= 1'b0;
            s01_axi_wready  <= 1'b1;
            s01_axi_bid     <= s01_axi_awid;
            werr   <= hdr_err(s01_axi_awsize, s01_axi_awburst,
                              s01_axi_awlen);
            wstate <= W_DATA;
          end else begin
            s01_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            werr <= werr | w_beat_err;
            if (w_last) begin
              s01_axi_wready <= 1'b0;
              s01_axi_bvalid <= 1'b1;
              s01_axi_bresp  <= (werr | w_beat_err) ?
                                RESP_SLVERR : RESP_OKAY;
              wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s01_axi_bready) begin
            s01_axi_bvalid  <= 1'b0;
            s01_axi_awready <= 1'b1;
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // read channel FSM: AR prefetches beat 0, each R handshake loads the next
  always_ff @(posedge s01_axi_aclk or posedge s01_axi_areset) begin
    if (s01_axi_areset) begin
      rstate          <= R_IDLE;
      rerr            <= 1'b0;
      s01_axi_arready <= 1'b0;
      s01_axi_rvalid  <= 1'b0;
      s01_axi_rlast   <= 1'b0;
      s01_axi_rresp   <= RESP_OKAY;
      s01_axi_rid     <= '0;
      s01_axi_rdata   <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            s01_axi_arready <= 1'b0;
            s01_axi_rvalid  <= 1'b1;
            s01_axi_rid     <= s01_axi_arid;
            s01_axi_rlast   <= (s01_axi_arlen == 8'd0);
            s01_axi_rdata   <= ar_oor ? '0 : mem[ar_start[MW-1:0]];
            s01_axi_rresp   <= (ar_herr | ar_oor) ?
                               RESP_SLVERR : RESP_OKAY;
            rerr   <= ar_herr;
            rstate <= R_DATA;
          end else begin
            s01_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s01_axi_rready) begin
            if (s01_axi_rlast) begin
              s01_axi_rvalid  <= 1'b0;
              s01_axi_rlast   <= 1'b0;
              s01_axi_arready <= 1'b1;
              rstate <= R_IDLE;
            end else begin
              s01_axi_rdata <= r_nxt_oor ? '0 : mem[r_nxt[MW-1:0]];
              s01_axi_rresp <= (rerr | r_nxt_oor) ?
                               RESP_SLVERR : RESP_OKAY;
              s01_axi_rlast <= r_nxt_last;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
